rf_writeback: RTL and testbench
===============================

RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 64: number of architectural registers.
REQ-002 The block SHALL have parameter DATA_W, default 32: register data width.
REQ-003 The block SHALL have parameter ADDR_W, default 6: register address width.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: entries per source buffer.
REQ-005 The block SHALL have port clk, input, 1: single clock; one clock, all state on rising edge.
REQ-006 The block SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-007 The block SHALL have ports alu_valid (in, 1), alu_ready (out, 1), alu_waddr (in, ADDR_W) and alu_wdata (in, DATA_W): ALU result channel.
REQ-008 The block SHALL have ports lsu_valid (in, 1), lsu_ready (out, 1), lsu_waddr (in, ADDR_W) and lsu_wdata (in, DATA_W): load/store result channel.
REQ-009 The block SHALL have ports iss_valid (in, 1) and iss_waddr (in, ADDR_W): issue stage marks a destination pending.
REQ-010 The block SHALL have ports pend_raddr_0 and pend_raddr_1 (in, ADDR_W): scoreboard query addresses.
REQ-011 The block SHALL have ports pend_0 and pend_1 (out, 1): pending status of the queried registers.
REQ-012 The block SHALL have ports write_en (out, 1), waddr (out, ADDR_W) and wdata (out, DATA_W): drive the register file write port.

Function
REQ-013 A source transfer SHALL occur on a rising edge where valid and ready are both 1; {waddr, wdata} is pushed into that source's FIFO.
REQ-014 Each ready output SHALL be registered-free and equal (count < FIFO_DEPTH) and not reset; valid while ready=0 is ignored, no push/pop pass-through when full.
REQ-015 Each cycle the arbiter SHALL grant at most one non-empty FIFO head: if one is non-empty, grant it; if both are non-empty, round-robin starting with ALU after reset and alternating after each dual-contention grant.
REQ-016 On the edge after a grant, write_en SHALL be 1 and waddr/wdata SHALL equal the granted head, which is popped at that edge; otherwise write_en SHALL be 0 and waddr/wdata SHALL hold their values.
REQ-017 Latency SHALL be: push at edge N gives write_en=1 during cycle N+1..N+2 at the earliest, so the register file captures at edge N+2, with no combinational input-to-output path.
REQ-018 Each FIFO SHALL preserve arrival order; ordering between sources is not guaranteed, because same-register WAW across sources is prevented by the issue stage.
REQ-019 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop SHALL leave the count unchanged.
REQ-020 The scoreboard SHALL be a NUM_REGS-bit pending vector: a bit is set at an edge with iss_valid=1 for iss_waddr, and cleared at an edge with write_en=1 for waddr.
REQ-021 When a set and a clear hit the same address at the same edge, set SHALL win; a set on an already-pending register has no further effect.
REQ-022 pend_0 and pend_1 SHALL be combinational lookups: pend_x = pending[pend_raddr_x].

Reset
REQ-023 While reset=1 at an edge, all FIFOs SHALL be emptied, the round-robin pointer set to ALU, and the pending vector cleared.
REQ-024 While reset=1 at an edge, write_en, waddr and wdata SHALL be set to 0.
REQ-025 alu_ready and lsu_ready SHALL be 0 while reset=1 and 1 from the first cycle after reset deasserts.
REQ-026 A reset mid-operation SHALL discard buffered results without issuing any write_en.

Structure
REQ-027 Package rf_pkg SHALL hold NUM_REGS, DATA_W, ADDR_W and WB_FIFO_DEPTH, plus typedef wb_req_t {addr, data}.
REQ-028 Sub-module wb_fifo (depth/width parameterised, push/pop/full/empty/count) SHALL be instantiated twice; arbiter, scoreboard and output registers live in rf_writeback.

Verification
REQ-029 Scenario: ALU pushes {0x05, 0xDEADBEEF} at edge N -> write_en=1, waddr=0x05, wdata=0xDEADBEEF during cycle N+1..N+2, and write_en=0 afterward.
REQ-030 Scenario: both sources push every cycle with addresses ALU 0x01..0x08 and LSU 0x21..0x28 -> writes alternate ALU, LSU, ALU, ...; per-source order is kept; ready drops when count=4 and no data is lost.
REQ-031 Scenario: 5 back-to-back LSU pushes while the ALU floods -> lsu_ready=0 once 4 entries are held, and the 5th is accepted only after a pop.
REQ-032 Scenario: iss_valid with reg 0x3F, then its write later -> pend_0 for raddr 0x3F is 1 until the write edge, then 0; a same-edge issue and write to 0x3F leaves pend=1.
REQ-033 Scenario: reset asserted with 3 entries buffered -> no write_en afterward, both readys=0 during reset and 1 the next cycle, and all pend outputs=0.
REQ-034 Scenario: write all 64 registers via the ALU with data {addr, 26'h1} -> each register gets exactly one write_en pulse with the matching data.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: shared sizing, request type and source encoding for the writeback path
package rf_pkg;
  localparam int NUM_REGS = 64;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int WB_FIFO_DEPTH = 4;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
  typedef enum logic {SRC_ALU, SRC_LSU} src_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small circular buffer holding one source's pending writeback requests
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : PW'(p + 1'b1);
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= inc(wr);
      if (do_pop) rd <= inc(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: merges ALU and LSU results onto one register-file write port
// with round-robin arbitration and a pending-register scoreboard.
module rf_writeback #(
  parameter int NUM_REGS = rf_pkg::NUM_REGS,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int FIFO_DEPTH = rf_pkg::WB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_waddr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_waddr,
  input  logic [ADDR_W-1:0] pend_raddr_0,
  input  logic [ADDR_W-1:0] pend_raddr_1,
  output logic              pend_0,
  output logic              pend_1,
  output logic              write_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);
  import rf_pkg::*;
  localparam int W = ADDR_W + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [W-1:0] alu_head, lsu_head;
  logic [CW-1:0] alu_cnt, lsu_cnt;
  logic alu_full, lsu_full, alu_empty, lsu_empty, alu_pop, lsu_pop, both;
  logic [NUM_REGS-1:0] pending, set_mask, clr_mask;
  src_e rr;
  assign alu_ready = !alu_full && !reset;
  assign lsu_ready = !lsu_full && !reset;
  wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(W)) u_alu_fifo (
    .clk(clk), .reset(reset), .push(alu_valid && alu_ready), .din({alu_waddr, alu_wdata}),
    .pop(alu_pop), .dout(alu_head), .full(alu_full), .empty(alu_empty), .count(alu_cnt)
  );
  wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(W)) u_lsu_fifo (
    .clk(clk), .reset(reset), .push(lsu_valid && lsu_ready), .din({lsu_waddr, lsu_wdata}),
    .pop(lsu_pop), .dout(lsu_head), .full(lsu_full), .empty(lsu_empty), .count(lsu_cnt)
  );
  // rr only matters (and only advances) when both heads compete
  assign both = !alu_empty && !lsu_empty;
  assign alu_pop = !alu_empty && (lsu_empty || rr == SRC_ALU);
  assign lsu_pop = !lsu_empty && (alu_empty || rr == SRC_LSU);
  assign set_mask = iss_valid ? NUM_REGS'(1) << iss_waddr : '0;
  assign clr_mask = write_en ? NUM_REGS'(1) << waddr : '0;
  assign pend_0 = pending[pend_raddr_0];
  assign pend_1 = pending[pend_raddr_1];
  always_ff @(posedge clk) begin
    if (reset) begin
      write_en <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      rr <= SRC_ALU;
      pending <= '0;
    end else begin
      write_en <= alu_pop || lsu_pop;
      if (alu_pop || lsu_pop) {waddr, wdata} <= alu_pop ? alu_head : lsu_head;
      if (both) rr <= rr == SRC_ALU ? SRC_LSU : SRC_ALU;
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end
  a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
    alu_cnt <= CW'(FIFO_DEPTH) && lsu_cnt <= CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed vectors with hand-computed expectations for rf_writeback
module tb_rf_writeback;
  import rf_pkg::*;
  logic clk, reset;
  logic alu_valid, alu_ready, lsu_valid, lsu_ready, iss_valid;
  logic [5:0] alu_waddr, lsu_waddr, iss_waddr, pend_raddr_0, pend_raddr_1, waddr;
  logic [31:0] alu_wdata, lsu_wdata, wdata;
  logic pend_0, pend_1, write_en;
  int n_vec = 0, n_err = 0;
  wb_req_t log_q[$];

  rf_writeback dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr),
    .pend_raddr_0(pend_raddr_0), .pend_raddr_1(pend_raddr_1), .pend_0(pend_0), .pend_1(pend_1),
    .write_en(write_en), .waddr(waddr), .wdata(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (write_en) log_q.push_back({waddr, wdata});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flood(input int na, input int nl, input logic [5:0] abase, input logic [5:0] lbase,
                       output bit a_bp, output bit l_bp);
    int ai = 0, li = 0;
    bit ra, rl;
    a_bp = 0;
    l_bp = 0;
    for (int c = 0; c < 200 && (ai < na || li < nl); c++) begin
      alu_valid = ai < na;
      alu_waddr = 6'(abase + ai);
      alu_wdata = 32'hA000_0000 + 32'(ai);
      lsu_valid = li < nl;
      lsu_waddr = 6'(lbase + li);
      lsu_wdata = 32'hB000_0000 + 32'(li);
      ra = alu_ready;
      rl = lsu_ready;
      if (alu_valid && !ra) a_bp = 1;
      if (lsu_valid && !rl) l_bp = 1;
      tick();
      if (alu_valid && ra) ai++;
      if (lsu_valid && rl) li++;
    end
    alu_valid = 0;
    lsu_valid = 0;
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < 200 && log_q.size() < n; c++) tick();
    repeat (4) tick();
    chk("log_size", 64'(log_q.size()), 64'(n));
  endtask

  initial begin
    bit a_bp, l_bp;
    int ones;
    reset = 1; alu_valid = 0; lsu_valid = 0; iss_valid = 0;
    alu_waddr = 0; lsu_waddr = 0; iss_waddr = 0; alu_wdata = 0; lsu_wdata = 0;
    pend_raddr_0 = 6'h3F; pend_raddr_1 = 6'h00;
    repeat (2) tick();
    chk("rst_write_en", 64'(write_en), 0);
    chk("rst_waddr", 64'(waddr), 0);
    chk("rst_wdata", 64'(wdata), 0);
    chk("rst_alu_ready", 64'(alu_ready), 0);
    chk("rst_lsu_ready", 64'(lsu_ready), 0);
    chk("rst_pend_0", 64'(pend_0), 0);
    reset = 0;
    #1;
    chk("rel_alu_ready", 64'(alu_ready), 1);
    chk("rel_lsu_ready", 64'(lsu_ready), 1);

    // single ALU write latency
    alu_valid = 1; alu_waddr = 6'h05; alu_wdata = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    chk("lat_n0_we", 64'(write_en), 0);
    tick();
    chk("lat_n1_we", 64'(write_en), 1);
    chk("lat_n1_waddr", 64'(waddr), 64'h05);
    chk("lat_n1_wdata", 64'(wdata), 64'hDEADBEEF);
    tick();
    chk("lat_n2_we", 64'(write_en), 0);
    chk("lat_n2_hold", 64'(waddr), 64'h05);

    // dual-source flood: strict alternation, backpressure, no loss
    log_q.delete();
    flood(8, 8, 6'h01, 6'h21, a_bp, l_bp);
    chk("alu_backpressure", 64'(a_bp), 1);
    chk("lsu_backpressure", 64'(l_bp), 1);
    drain(16);
    for (int i = 0; i < 16 && i < log_q.size(); i++) begin
      logic [37:0] e;
      e = (i % 2 == 0) ? {6'(6'h01 + i / 2), 32'hA000_0000 + 32'(i / 2)}
                       : {6'(6'h21 + i / 2), 32'hB000_0000 + 32'(i / 2)};
      chk($sformatf("flood_%0d", i), 64'(log_q[i]), 64'(e));
    end

    // scoreboard set/clear and set-wins
    iss_valid = 1; iss_waddr = 6'h3F; pend_raddr_0 = 6'h3F; pend_raddr_1 = 6'h3E;
    #1;
    chk("pend_pre", 64'(pend_0), 0);
    tick();
    iss_valid = 0;
    chk("pend_set", 64'(pend_0), 1);
    chk("pend_other", 64'(pend_1), 0);
    alu_valid = 1; alu_waddr = 6'h3F; alu_wdata = 32'h1234_5678;
    tick();
    alu_valid = 0;
    tick();
    chk("pend_we", 64'(write_en), 1);
    chk("pend_before_clr", 64'(pend_0), 1);
    tick();
    chk("pend_clr", 64'(pend_0), 0);
    alu_valid = 1;
    tick();
    alu_valid = 0;
    tick();
    iss_valid = 1;
    tick();
    iss_valid = 0;
    chk("pend_set_wins", 64'(pend_0), 1);
    tick();
    chk("pend_set_hold", 64'(pend_0), 1);

    // reset with buffered entries
    alu_valid = 1; lsu_valid = 1; alu_waddr = 6'h0A; lsu_waddr = 6'h2A;
    iss_valid = 1; iss_waddr = 6'h10; pend_raddr_1 = 6'h10;
    tick();
    iss_valid = 0;
    chk("pre_rst_pend", 64'(pend_1), 1);
    tick();
    alu_valid = 0; lsu_valid = 0; reset = 1;
    #1;
    chk("midrst_alu_ready", 64'(alu_ready), 0);
    chk("midrst_lsu_ready", 64'(lsu_ready), 0);
    tick();
    chk("midrst_we", 64'(write_en), 0);
    chk("midrst_pend_0", 64'(pend_0), 0);
    chk("midrst_pend_1", 64'(pend_1), 0);
    reset = 0;
    #1;
    chk("postrst_alu_ready", 64'(alu_ready), 1);
    chk("postrst_lsu_ready", 64'(lsu_ready), 1);
    log_q.delete();
    repeat (8) tick();
    chk("postrst_no_write", 64'(log_q.size()), 0);

    // all 64 registers through the ALU, each issued then written back
    log_q.delete();
    for (int i = 0; i < 64; i++) begin
      alu_valid = 1; alu_waddr = 6'(i); alu_wdata = {6'(i), 26'h1};
      iss_valid = 1; iss_waddr = 6'(i);
      tick();
    end
    alu_valid = 0; iss_valid = 0;
    drain(64);
    for (int i = 0; i < 64 && i < log_q.size(); i++)
      chk($sformatf("all_%0d", i), 64'(log_q[i]), 64'({6'(i), 6'(i), 26'h1}));
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      pend_raddr_0 = 6'(i);
      #1;
      if (pend_0) ones++;
    end
    chk("all_pend_clear", 64'(ones), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
